// File: rtl/program_mem_loader.sv
// Program memory for the 4-bit processor with a built-in sequential valid/ready loader.
// Fetches are served with one-cycle registered latency and are dropped while a load is running.
module program_mem_loader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              busy_o,
  input  logic              fetch_en_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o
);

  typedef enum logic {IDLE, LOAD} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic              loadDone_q, loadDone_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instrValid_q, instrValid_d;
  logic              memWe;
  logic              fetchAccept;
  logic              fetchInRange;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      loadDone_q   <= 1'b0;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      loadDone_q   <= loadDone_d;
      instr_q      <= instr_d;
      instrValid_q <= instrValid_d;
    end
  end

  // A restart request in LOAD takes priority over a word presented in the same cycle.
  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    loadDone_d = 1'b0;
    memWe      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
          wrPtr_d = '0;
        end
      end
      LOAD: begin
        if (load_start_i) begin
          wrPtr_d = '0;
        end else if (load_valid_i) begin
          memWe = 1'b1;
          if (wrPtr_q == LastAddr) begin
            wrPtr_d    = '0;
            state_d    = IDLE;
            loadDone_d = 1'b1;
          end else begin
            wrPtr_d = wrPtr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses beyond the populated depth read back as zero but still count as a fetch.
  always_comb begin
    load_ready_o = (state_q == LOAD);
    busy_o       = (state_q == LOAD);
    fetchAccept  = fetch_en_i && (state_q == IDLE) && !load_start_i;
    fetchInRange = (int'(fetch_addr_i) < DEPTH);
    instr_d      = instr_q;
    instrValid_d = 1'b0;
    if (fetchAccept) begin
      instr_d      = fetchInRange ? mem[fetch_addr_i] : '0;
      instrValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wrPtr_q] <= load_data_i;
    end
  end

  assign load_done_o   = loadDone_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instrValid_q;

endmodule

// File: tb/tb_program_mem_loader.sv
// Self-checking bench for program_mem_loader: a 16-word instance for load/fetch behaviour
// and a 12-word instance for the short-depth and out-of-range fetch cases.
module tb_program_mem_loader;

  typedef struct packed {
    logic [3:0] instr;
    logic       valid;
  } expT;

  typedef struct {
    logic       en;
    logic [3:0] addr;
    logic [3:0] expInstr;
    logic       expValid;
  } fetchVecT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       loadStart, loadValid, loadReady, loadDone, busy;
  logic [3:0] loadData;
  logic       fetchEn, instrValid;
  logic [3:0] fetchAddr, instr;

  logic       bStart, bValid, bReady, bDone, bBusy;
  logic [3:0] bData;
  logic       bEn, bInstrValid;
  logic [3:0] bAddr, bInstr;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] model [16];
  logic [3:0] heldInstr = 4'h0;
  expT        sbQueue [$];
  fetchVecT   vecs [7];

  always #5 clk = ~clk;

  program_mem_loader #(.DATA_W(4), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(loadStart), .load_valid_i(loadValid), .load_data_i(loadData),
    .load_ready_o(loadReady), .load_done_o(loadDone), .busy_o(busy),
    .fetch_en_i(fetchEn), .fetch_addr_i(fetchAddr),
    .instr_o(instr), .instr_valid_o(instrValid)
  );

  program_mem_loader #(.DATA_W(4), .ADDR_W(4), .DEPTH(12)) dutShort (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(bStart), .load_valid_i(bValid), .load_data_i(bData),
    .load_ready_o(bReady), .load_done_o(bDone), .busy_o(bBusy),
    .fetch_en_i(bEn), .fetch_addr_i(bAddr),
    .instr_o(bInstr), .instr_valid_o(bInstrValid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] imageWord(input int kind, input int i);
    return (kind == 0) ? 4'(15 - i) : 4'(i + 1);
  endfunction

  // Drives one fetch cycle and records what the DUT must show after the next edge.
  task automatic applyStimulus(input logic en, input logic [3:0] addr,
                               input logic [3:0] expInstr, input logic expValid);
    expT e;
    fetchEn   = en;
    fetchAddr = addr;
    e.instr   = expInstr;
    e.valid   = expValid;
    sbQueue.push_back(e);
  endtask

  task automatic fetchExpect(input logic en, input logic [3:0] addr, input logic accepted);
    if (accepted) heldInstr = model[addr];
    applyStimulus(en, addr, heldInstr, accepted);
  endtask

  task automatic checkOutput(input string name);
    expT e;
    if (sbQueue.size() == 0) begin
      check({name, "_sbEmpty"}, 32'd1, 32'd0);
    end else begin
      e = sbQueue.pop_front();
      check({name, "_instr"}, 32'(instr), 32'(e.instr));
      check({name, "_valid"}, 32'(instrValid), 32'(e.valid));
    end
  endtask

  task automatic loadImage(input int kind, input bit gaps);
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    check("busyAfterStart", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        loadValid = 1'b0;
        tick();
        check("doneDuringGap", 32'(loadDone), 32'd0);
      end
      loadValid = 1'b1;
      loadData  = imageWord(kind, i);
      check("loadReady", 32'(loadReady), 32'd1);
      tick();
      model[i] = imageWord(kind, i);
      if (i < 15) check("doneEarly", 32'(loadDone), 32'd0);
    end
    check("donePulse", 32'(loadDone), 32'd1);
    check("busyFalls", 32'(busy), 32'd0);
    loadValid = 1'b0;
    tick();
    check("doneOneCycle", 32'(loadDone), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    loadStart = 1'b0; loadValid = 1'b0; loadData = 4'h0;
    fetchEn = 1'b0; fetchAddr = 4'h0;
    bStart = 1'b0; bValid = 1'b0; bData = 4'h0; bEn = 1'b0; bAddr = 4'h0;
    vecs[0] = '{1'b1, 4'd3,  4'hC, 1'b1};
    vecs[1] = '{1'b0, 4'd3,  4'hC, 1'b0};
    vecs[2] = '{1'b0, 4'd9,  4'hC, 1'b0};
    vecs[3] = '{1'b1, 4'd0,  4'hF, 1'b1};
    vecs[4] = '{1'b1, 4'd15, 4'h0, 1'b1};
    vecs[5] = '{1'b1, 4'd8,  4'h7, 1'b1};
    vecs[6] = '{1'b0, 4'd2,  4'h7, 1'b0};

    tick();
    tick();
    check("rstBusy", 32'(busy), 32'd0);
    check("rstReady", 32'(loadReady), 32'd0);
    check("rstDone", 32'(loadDone), 32'd0);
    check("rstInstr", 32'(instr), 32'd0);
    check("rstValid", 32'(instrValid), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] full load, no gaps");
    loadImage(0, 1'b0);

    $display("[TB] fetch vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].en, vecs[i].addr, vecs[i].expInstr, vecs[i].expValid);
      if (vecs[i].expValid) heldInstr = vecs[i].expInstr;
      tick();
      checkOutput($sformatf("vec%0d", i));
    end

    $display("[TB] load with gaps and full readback");
    loadImage(0, 1'b1);
    for (int i = 15; i >= 0; i--) begin
      fetchExpect(1'b1, 4'(i), 1'b1);
      tick();
      checkOutput($sformatf("read%0d", i));
    end
    fetchEn = 1'b0;

    $display("[TB] fetch during load, load_start beats fetch");
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    fetchExpect(1'b1, 4'd5, 1'b0);
    tick();
    checkOutput("fetchInLoad");
    fetchEn = 1'b0;
    loadImage(0, 1'b0);
    loadStart = 1'b1;
    fetchExpect(1'b1, 4'd5, 1'b0);
    tick();
    checkOutput("startBeatsFetch");
    check("startBeatsFetchBusy", 32'(busy), 32'd1);
    loadStart = 1'b0;
    fetchEn = 1'b0;

    $display("[TB] partial load then restart");
    for (int i = 0; i < 7; i++) begin
      loadValid = 1'b1;
      loadData  = 4'h5;
      tick();
      model[i] = 4'h5;
    end
    loadValid = 1'b0;
    loadImage(1, 1'b0);
    fetchExpect(1'b1, 4'd0, 1'b1);
    tick();
    checkOutput("restartAddr0");
    fetchExpect(1'b1, 4'd6, 1'b1);
    tick();
    checkOutput("restartAddr6");
    fetchExpect(1'b1, 4'd15, 1'b1);
    tick();
    checkOutput("restartAddr15");
    fetchEn = 1'b0;

    $display("[TB] reset in the middle of a load");
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      loadValid = 1'b1;
      loadData  = 4'hE;
      tick();
      model[i] = 4'hE;
    end
    loadValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midRstBusy", 32'(busy), 32'd0);
    check("midRstReady", 32'(loadReady), 32'd0);
    check("midRstInstr", 32'(instr), 32'd0);
    heldInstr = 4'h0;
    tick();
    check("midRstDone", 32'(loadDone), 32'd0);
    rst_n = 1'b1;
    tick();
    check("postRstDone", 32'(loadDone), 32'd0);
    check("postRstBusy", 32'(busy), 32'd0);
    fetchExpect(1'b1, 4'd2, 1'b1);
    tick();
    checkOutput("retainedAddr2");
    fetchExpect(1'b1, 4'd7, 1'b1);
    tick();
    checkOutput("retainedAddr7");
    fetchEn = 1'b0;
    tick();

    $display("[TB] 12-word instance");
    bStart = 1'b1;
    tick();
    bStart = 1'b0;
    check("shortBusy", 32'(bBusy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      bValid = 1'b1;
      bData  = 4'(i) ^ 4'h9;
      check("shortReady", 32'(bReady), 32'd1);
      tick();
      if (i < 11) check("shortDoneEarly", 32'(bDone), 32'd0);
    end
    check("shortDone", 32'(bDone), 32'd1);
    check("shortBusyFalls", 32'(bBusy), 32'd0);
    bValid = 1'b0;
    bEn = 1'b1;
    bAddr = 4'd11;
    tick();
    check("shortAddr11", 32'(bInstr), 32'h2);
    check("shortAddr11Valid", 32'(bInstrValid), 32'd1);
    bAddr = 4'd13;
    tick();
    check("shortAddr13", 32'(bInstr), 32'h0);
    check("shortAddr13Valid", 32'(bInstrValid), 32'd1);
    bAddr = 4'd4;
    tick();
    check("shortAddr4", 32'(bInstr), 32'hD);
    bAddr = 4'd12;
    tick();
    check("shortAddr12", 32'(bInstr), 32'h0);
    check("shortAddr12Valid", 32'(bInstrValid), 32'd1);
    bEn = 1'b0;
    tick();
    check("shortIdleValid", 32'(bInstrValid), 32'd0);

    check("sbDrained", 32'(sbQueue.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
